// File: rtl/wu_event_logger.sv
// Wake-up latency logger: times trigger-to-wake_up intervals and stores
// tagged results in a circular buffer drained by a toggling host read request.
module wu_event_logger #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clki,
  input  logic        reset,
  input  logic        enable,
  input  logic        trig_to_siggen,
  input  logic        wake_up,
  input  logic        rd_toggle,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [6:0]  fill_level,
  output logic [15:0] overflow_cnt,
  output logic [15:0] spurious_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  localparam logic [29:0] TO_LAST = 30'(TIMEOUT - 1);
  localparam logic [29:0] TO_VAL  = 30'(TIMEOUT);

  // Synchronizers and edge registers
  logic        wu_s1_q, wu_s2_q, wu_d_q;
  logic        rt_s1_q, rt_s2_q, rt_d_q;
  logic [1:0]  settle_q;
  logic        trig_q;

  logic [0:0]  state_q, state_d;
  logic [29:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0] spurious_q, spurious_d;
  logic [15:0] overflow_q, overflow_d;

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, used;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  logic        wu_edge, rt_edge, trig_edge;
  logic        push, push_ok, do_pop, empty, full;
  logic [31:0] push_data;

  assign wu_edge   = wu_s2_q & ~wu_d_q;
  // The first transitions out of reset only reflect the synchronizer filling up.
  assign rt_edge   = (rt_s2_q ^ rt_d_q) & (settle_q == 2'd3);
  assign trig_edge = trig_to_siggen & ~trig_q;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 30'd1;

  assign used   = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = rt_edge & ~empty;
  assign push_ok = push & (~full | do_pop);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    spurious_d = spurious_q;
    push       = 1'b0;
    push_data  = '0;
    case (state_q)
      IDLE: begin
        if (wu_edge && spurious_q != '1) spurious_d = spurious_q + 16'd1;
        if (trig_edge && enable) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_inc;
        if (wu_edge || cnt_q == TO_LAST) begin
          push      = 1'b1;
          push_data = wu_edge ? {2'b00, cnt_inc} : {2'b10, TO_VAL};
          state_d   = IDLE;
          if (trig_edge && enable) begin
            state_d = ARMED;
            cnt_d   = '0;
          end
        end else if (trig_edge) begin
          push      = 1'b1;
          push_data = {2'b11, cnt_inc};
          cnt_d     = '0;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(do_pop);
    overflow_d = overflow_q;
    if (push && !push_ok && overflow_q != '1) overflow_d = overflow_q + 16'd1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clki) begin
    if (!reset) begin
      wu_s1_q    <= 1'b0;
      wu_s2_q    <= 1'b0;
      wu_d_q     <= 1'b0;
      rt_s1_q    <= 1'b0;
      rt_s2_q    <= 1'b0;
      rt_d_q     <= 1'b0;
      settle_q   <= '0;
      trig_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      spurious_q <= '0;
      overflow_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wu_s1_q    <= wake_up;
      wu_s2_q    <= wu_s1_q;
      wu_d_q     <= wu_s2_q;
      rt_s1_q    <= rd_toggle;
      rt_s2_q    <= rt_s1_q;
      rt_d_q     <= rt_s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      trig_q     <= trig_to_siggen;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spurious_q <= spurious_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      rd_valid_q <= ~empty;
    end
  end

  // NOTE: the log memory is deliberately not reset; stale words are masked by the pointers.
  always_ff @(posedge clki) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign fill_level   = 7'(used);
  assign overflow_cnt = overflow_q;
  assign spurious_cnt = spurious_q;

endmodule

// File: tb/tb_wu_event_logger.sv
// Directed self-checking bench for wu_event_logger (DEPTH=16, TIMEOUT=1000).
module tb_wu_event_logger;

  logic        clki = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic        wake = 1'b0;
  logic        rdt = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [6:0]  fill_level;
  logic [15:0] overflow_cnt;
  logic [15:0] spurious_cnt;

  int n_vec = 0;
  int n_bad = 0;

  wu_event_logger #(.DEPTH(16), .TIMEOUT(1000)) dut (
    .clki           (clki),
    .reset          (reset),
    .enable         (enable),
    .trig_to_siggen (trig),
    .wake_up        (wake),
    .rd_toggle      (rdt),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .fill_level     (fill_level),
    .overflow_cnt   (overflow_cnt),
    .spurious_cnt   (spurious_cnt)
  );

  always #5 clki = ~clki;

  task automatic cycles(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  // Leaves the bench 1ns after the clock edge that samples the trigger edge.
  task automatic fire();
    trig = 1'b1;
    cycles(1);
    trig = 1'b0;
  endtask

  task automatic pop();
    rdt = ~rdt;
    cycles(4);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycles(3);
    n_vec++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got %h exp %h", rd_data, 32'h0); end
    n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
    n_vec++; if (overflow_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_ovf got %0d exp 0", overflow_cnt); end
    n_vec++; if (spurious_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_spur got %0d exp 0", spurious_cnt); end
    reset = 1'b1;
    enable = 1'b1;
    cycles(4);
  endtask

  task automatic test_wakeup();
    fire();
    cycles(497);
    wake = 1'b1;
    cycles(4);
    n_vec++; if (rd_data !== 32'h000001F4) begin n_bad++; $display("FAIL wakeup_entry got %h exp %h", rd_data, 32'h000001F4); end
    n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL wakeup_valid got %b exp 1", rd_valid); end
    n_vec++; if (fill_level !== 7'd1) begin n_bad++; $display("FAIL wakeup_fill got %0d exp 1", fill_level); end
    wake = 1'b0;
    pop();
    n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL wakeup_popped_valid got %b exp 0", rd_valid); end
    n_vec++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL wakeup_popped_data got %h exp 0", rd_data); end
  endtask

  task automatic test_timeout();
    fire();
    cycles(999);
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL timeout_early got %0d exp 0", fill_level); end
    cycles(2);
    n_vec++; if (rd_data !== 32'h800003E8) begin n_bad++; $display("FAIL timeout_entry got %h exp %h", rd_data, 32'h800003E8); end
    n_vec++; if (fill_level !== 7'd1) begin n_bad++; $display("FAIL timeout_fill got %0d exp 1", fill_level); end
    wake = 1'b1;
    cycles(4);
    n_vec++; if (spurious_cnt !== 16'd1) begin n_bad++; $display("FAIL timeout_spur got %0d exp 1", spurious_cnt); end
    n_vec++; if (fill_level !== 7'd1) begin n_bad++; $display("FAIL timeout_spur_nopush got %0d exp 1", fill_level); end
    wake = 1'b0;
    pop();
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL timeout_drain got %0d exp 0", fill_level); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    fire();
    cycles(2);
    wake = 1'b1;
    cycles(4);
    n_vec++; if (spurious_cnt !== 16'd2) begin n_bad++; $display("FAIL disabled_spur got %0d exp 2", spurious_cnt); end
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL disabled_fill got %0d exp 0", fill_level); end
    wake = 1'b0;
    enable = 1'b1;
    cycles(2);
    fire();
    enable = 1'b0;
    cycles(17);
    wake = 1'b1;
    cycles(4);
    n_vec++; if (rd_data !== 32'h00000014) begin n_bad++; $display("FAIL disable_armed_entry got %h exp %h", rd_data, 32'h00000014); end
    wake = 1'b0;
    enable = 1'b1;
    pop();
  endtask

  task automatic test_retrigger();
    fire();
    cycles(199);
    fire();
    cycles(47);
    wake = 1'b1;
    cycles(4);
    n_vec++; if (fill_level !== 7'd2) begin n_bad++; $display("FAIL retrig_fill got %0d exp 2", fill_level); end
    n_vec++; if (rd_data !== 32'hC00000C8) begin n_bad++; $display("FAIL retrig_first got %h exp %h", rd_data, 32'hC00000C8); end
    wake = 1'b0;
    pop();
    n_vec++; if (rd_data !== 32'h00000032) begin n_bad++; $display("FAIL retrig_second got %h exp %h", rd_data, 32'h00000032); end
    pop();
    n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL retrig_empty got %b exp 0", rd_valid); end
  endtask

  // 19 trigger edges with gaps 3..21 log 18 re-trigger entries of value 3..20.
  task automatic test_overflow();
    for (int i = 0; i < 19; i++) begin
      trig = 1'b1;
      cycles(1);
      trig = 1'b0;
      cycles(i + 2);
    end
    n_vec++; if (fill_level !== 7'd16) begin n_bad++; $display("FAIL ovf_fill got %0d exp 16", fill_level); end
    n_vec++; if (overflow_cnt !== 16'd2) begin n_bad++; $display("FAIL ovf_cnt got %0d exp 2", overflow_cnt); end
    n_vec++; if (rd_data !== 32'hC0000003) begin n_bad++; $display("FAIL ovf_head got %h exp %h", rd_data, 32'hC0000003); end
    n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %b exp 1", rd_valid); end
  endtask

  // Wake edge 23 cycles after the last trigger lands with a pop on a full buffer.
  task automatic test_full_push_pop();
    rdt = ~rdt;
    wake = 1'b1;
    cycles(4);
    n_vec++; if (fill_level !== 7'd16) begin n_bad++; $display("FAIL fullpp_fill got %0d exp 16", fill_level); end
    n_vec++; if (overflow_cnt !== 16'd2) begin n_bad++; $display("FAIL fullpp_ovf got %0d exp 2", overflow_cnt); end
    n_vec++; if (rd_data !== 32'hC0000004) begin n_bad++; $display("FAIL fullpp_head got %h exp %h", rd_data, 32'hC0000004); end
    wake = 1'b0;
  endtask

  task automatic test_drain();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? (32'hC0000000 | 32'(i + 4)) : 32'h00000017;
      n_vec++; if (rd_data !== exp) begin n_bad++; $display("FAIL drain_%0d got %h exp %h", i, rd_data, exp); end
      pop();
    end
    n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b exp 0", rd_valid); end
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL drain_fill got %0d exp 0", fill_level); end
    pop();
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL empty_pop_fill got %0d exp 0", fill_level); end
    n_vec++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL empty_pop_data got %h exp 0", rd_data); end
  endtask

  task automatic test_reset_armed();
    fire();
    for (int i = 0; i < 3; i++) begin
      cycles(4);
      fire();
    end
    cycles(2);
    n_vec++; if (fill_level !== 7'd3) begin n_bad++; $display("FAIL rstarm_pre_fill got %0d exp 3", fill_level); end
    n_vec++; if (rd_data !== 32'hC0000005) begin n_bad++; $display("FAIL rstarm_pre_head got %h exp %h", rd_data, 32'hC0000005); end
    reset = 1'b0;
    cycles(2);
    n_vec++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rstarm_data got %h exp 0", rd_data); end
    n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rstarm_valid got %b exp 0", rd_valid); end
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL rstarm_fill got %0d exp 0", fill_level); end
    n_vec++; if (overflow_cnt !== 16'd0) begin n_bad++; $display("FAIL rstarm_ovf got %0d exp 0", overflow_cnt); end
    n_vec++; if (spurious_cnt !== 16'd0) begin n_bad++; $display("FAIL rstarm_spur got %0d exp 0", spurious_cnt); end
    reset = 1'b1;
    cycles(30);
    n_vec++; if (fill_level !== 7'd0) begin n_bad++; $display("FAIL rstarm_nopush got %0d exp 0", fill_level); end
    fire();
    cycles(7);
    wake = 1'b1;
    cycles(4);
    n_vec++; if (rd_data !== 32'h0000000A) begin n_bad++; $display("FAIL rstarm_relog got %h exp %h", rd_data, 32'h0000000A); end
    n_vec++; if (fill_level !== 7'd1) begin n_bad++; $display("FAIL rstarm_relog_fill got %0d exp 1", fill_level); end
    wake = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_timeout();
    test_enable();
    test_retrigger();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_reset_armed();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
